// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
//
// Reset sequencer for four downstream clock domains. Holds every domain in
// reset, waits for the PLL to lock, then releases the domain resets one at a
// time. Once all four are released it supervises the system with a watchdog.
// A lock loss, a watchdog expiry or a software request restarts the sequence
// and records which event caused it.
//
// Ports
//   clk_in        in   1  system clock, rising edge
//   rst_in        in   1  asynchronous active-low reset (deassertion is
//                         synchronised internally)
//   pll_locked    in   1  asynchronous PLL lock status
//   soft_rst_req  in   1  single-cycle software reset request
//   wdt_kick      in   1  watchdog refresh pulse (ignored outside RUN)
//   rst_n_out     out  4  active-low domain resets, bit 0 released first
//   seq_done      out  1  high while the sequence is complete (RUN)
//   rst_cause     out  2  00 power-on, 01 soft, 10 watchdog, 11 lock loss
// -----------------------------------------------------------------------------
module rst_seq_ctrl #(
  parameter int HOLD_CYC  = 16,
  parameter int STAGE_DLY = 8,
  parameter int WDT_CYC   = 1000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  input  logic       wdt_kick,
  output logic [3:0] rst_n_out,
  output logic       seq_done,
  output logic [1:0] rst_cause
);

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] STAGE_LAST = 16'(STAGE_DLY - 1);
  localparam logic [15:0] WDT_LAST   = 16'(WDT_CYC - 1);

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_SOFT = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;
  localparam logic [1:0] CAUSE_LOCK = 2'b11;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Event priority: lock loss beats watchdog beats software request.
  function automatic logic [1:0] event_cause(input logic lock_loss,
                                             input logic wdt_exp);
    if (lock_loss)    return CAUSE_LOCK;
    else if (wdt_exp) return CAUSE_WDT;
    else              return CAUSE_SOFT;
  endfunction

  // ---- stage p0/p1: reset deassertion synchroniser ----
  logic rst_sync_p0;
  logic rst_sync_p1;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rst_sync_p0 <= 1'b0;
      rst_sync_p1 <= 1'b0;
    end else begin
      rst_sync_p0 <= 1'b1;
      rst_sync_p1 <= rst_sync_p0;
    end
  end

  // Internal reset is active while the synchroniser still carries a zero.
  logic run_en;
  assign run_en = rst_sync_p1;

  // ---- stage p0/p1: PLL lock synchroniser ----
  logic lock_p0;
  logic lock_p1;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
    end else if (!run_en) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
    end else begin
      lock_p0 <= pll_locked;
      lock_p1 <= lock_p0;
    end
  end

  // ---- sequencer state and counters ----
  state_t      state;
  state_t      state_nxt;
  logic [15:0] hold_cnt;
  logic [15:0] hold_nxt;
  logic [15:0] stage_cnt;
  logic [15:0] stage_nxt;
  logic [15:0] wdt_cnt;
  logic [15:0] wdt_nxt;
  logic [3:0]  rst_n_nxt;
  logic        done_nxt;
  logic [1:0]  cause_nxt;

  logic lock_loss;
  logic wdt_exp;

  // Lock loss only matters once releasing has begun; in WAIT_LOCK we are
  // already waiting for lock. A kick in the expiry cycle suppresses expiry.
  assign lock_loss = !lock_p1 && ((state == ST_RELEASE) || (state == ST_RUN));
  assign wdt_exp   = (state == ST_RUN) && (wdt_cnt == WDT_LAST) && !wdt_kick;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    stage_nxt = stage_cnt;
    wdt_nxt   = wdt_cnt;
    rst_n_nxt = rst_n_out;
    done_nxt  = seq_done;
    cause_nxt = rst_cause;

    if (!run_en) begin
      state_nxt = ST_ASSERT;
      hold_nxt  = 16'd0;
      stage_nxt = 16'd0;
      wdt_nxt   = 16'd0;
      rst_n_nxt = 4'b0000;
      done_nxt  = 1'b0;
      cause_nxt = CAUSE_POR;
    end else if (lock_loss || wdt_exp || soft_rst_req) begin
      // Any event restarts the whole sequence, including from ASSERT itself
      // (where it restarts the hold count) and from WAIT_LOCK.
      state_nxt = ST_ASSERT;
      hold_nxt  = 16'd0;
      stage_nxt = 16'd0;
      wdt_nxt   = 16'd0;
      rst_n_nxt = 4'b0000;
      done_nxt  = 1'b0;
      cause_nxt = event_cause(lock_loss, wdt_exp);
    end else begin
      unique case (state)
        ST_ASSERT: begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt = ST_WAIT_LOCK;
            hold_nxt  = 16'd0;
          end else begin
            hold_nxt = sat_inc(hold_cnt);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_p1) begin
            state_nxt = ST_RELEASE;
            stage_nxt = 16'd0;
            rst_n_nxt = 4'b0001;
          end
        end
        ST_RELEASE: begin
          if (stage_cnt == STAGE_LAST) begin
            stage_nxt = 16'd0;
            rst_n_nxt = {rst_n_out[2:0], 1'b1};
            // Releasing the last domain completes the sequence.
            if (rst_n_out[2]) begin
              state_nxt = ST_RUN;
              done_nxt  = 1'b1;
              wdt_nxt   = 16'd0;
            end
          end else begin
            stage_nxt = sat_inc(stage_cnt);
          end
        end
        ST_RUN: begin
          wdt_nxt = wdt_kick ? 16'd0 : sat_inc(wdt_cnt);
        end
        default: begin
          state_nxt = ST_ASSERT;
          hold_nxt  = 16'd0;
          stage_nxt = 16'd0;
          wdt_nxt   = 16'd0;
          rst_n_nxt = 4'b0000;
          done_nxt  = 1'b0;
        end
      endcase
    end
  end

  // ---- stage p2: registered state and outputs ----
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= ST_ASSERT;
      hold_cnt  <= 16'd0;
      stage_cnt <= 16'd0;
      wdt_cnt   <= 16'd0;
      rst_n_out <= 4'b0000;
      seq_done  <= 1'b0;
      rst_cause <= CAUSE_POR;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      stage_cnt <= stage_nxt;
      wdt_cnt   <= wdt_nxt;
      rst_n_out <= rst_n_nxt;
      seq_done  <= done_nxt;
      rst_cause <= cause_nxt;
    end
  end

endmodule
